// File: rtl/core_control_fsm_pkg.sv
// Shared encodings for the RV32-subset multi-cycle core: opcodes, FSM states,
// ALU operation codes, PC and writeback mux selects.
package core_control_fsm_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_ADD = 4'd0;
    localparam alu_code_t ALU_SUB = 4'd1;
    localparam alu_code_t ALU_AND = 4'd2;
    localparam alu_code_t ALU_OR  = 4'd3;
    localparam alu_code_t ALU_XOR = 4'd4;
    localparam alu_code_t ALU_SLL = 4'd5;
    localparam alu_code_t ALU_SRL = 4'd6;
    localparam alu_code_t ALU_SRA = 4'd7;
    localparam alu_code_t ALU_SLT = 4'd8;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Only beq/blt/bge exist in this subset.
    function automatic logic br_supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:  return eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_control_fsm_if.sv
// Request/ready handshake to the shared instruction+data memory port.
interface core_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_size;
    logic mem_is_data;
    logic mem_ready;

    modport master (output mem_req, mem_we, mem_size, mem_is_data, input mem_ready);
    modport slave  (input mem_req, mem_we, mem_size, mem_is_data, output mem_ready);
endinterface

// File: rtl/core_control_fsm_alu_control.sv
// Combinational ALU operation decode from {opcode, func3, func7}; flags
// R/I-type func3 encodings that the ALU does not implement.
module core_control_fsm_alu_control
    import core_control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_code_t  alu_op,
    output logic       illegal_alu
);

    logic alt;
    logic is_arith;
    logic unused_f7;

    assign alt       = func7[5];
    assign is_arith  = (opcode == OP_R) || (opcode == OP_I);
    assign unused_f7 = ^{func7[6], func7[4:0]};

    always_comb begin
        alu_op      = ALU_ADD;
        illegal_alu = 1'b0;
        if (is_arith) begin
            case (func3)
                // Immediate forms have no SUB; func7[5] only distinguishes SRAI.
                3'b000:  alu_op = ((opcode == OP_R) && alt) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_op = ALU_AND;
                3'b110:  alu_op = ALU_OR;
                3'b100:  alu_op = ALU_XOR;
                3'b001:  alu_op = ALU_SLL;
                3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
                3'b010:  alu_op = ALU_SLT;
                default: illegal_alu = 1'b1;
            endcase
        end else if (opcode == OP_B) begin
            alu_op = ALU_SUB;
        end
    end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the RV32-subset core.
// Moore outputs are registered from the next state; write strobes follow the leaving condition.
module core_control_fsm
    import core_control_fsm_pkg::*;
#(
    parameter int ALU_OPW = 4,
    parameter int STATE_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic                 size,
    input  logic                 br_eq,
    input  logic                 br_lt,
    core_control_fsm_if.master   mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_imm,
    output logic [ALU_OPW-1:0]   alu_op,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state_o
);

    state_t    state;
    state_t    state_nx;
    alu_code_t alu_code;
    logic      illegal_alu;
    logic      is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr;
    logic      done;
    logic      br_ok;
    logic [1:0] pc_src_q;

    core_control_fsm_alu_control u_alu_control (
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .alu_op      (alu_code),
        .illegal_alu (illegal_alu)
    );

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_l    = (opcode == OP_L);
    assign is_s    = (opcode == OP_S);
    assign is_b    = (opcode == OP_B);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    // A ready without an outstanding request never completes anything.
    assign done  = mem.mem_req && mem.mem_ready;
    assign br_ok = br_supported(func3);

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH:  if (done) state_nx = ST_DECODE;
            ST_DECODE: begin
                if (((is_r || is_i) && !illegal_alu) || is_l || is_s) state_nx = ST_EXEC;
                else if (is_b)                                        state_nx = ST_BRANCH;
                else if (is_jal || is_jalr)                           state_nx = ST_JUMP;
                else                                                  state_nx = ST_TRAP;
            end
            ST_EXEC:   state_nx = (is_l || is_s) ? ST_MEM : ST_WB;
            ST_MEM:    if (done) state_nx = is_l ? ST_WB : ST_FETCH;
            ST_WB:     state_nx = ST_FETCH;
            ST_BRANCH: state_nx = br_ok ? ST_FETCH : ST_TRAP;
            ST_JUMP:   state_nx = ST_FETCH;
            default:   state_nx = ST_TRAP;
        endcase
    end

    assign ir_write  = (state == ST_FETCH) && done;
    assign reg_write = (state == ST_WB) || (state == ST_JUMP);
    assign pc_write  = (state == ST_WB) || (state == ST_JUMP)
                     || ((state == ST_MEM) && is_s && done)
                     || ((state == ST_BRANCH) && br_ok);
    // Branch outcome depends on the compare flags seen during BRANCH itself.
    assign pc_src    = (state == ST_BRANCH)
                     ? (br_taken(func3, br_eq, br_lt) ? PC_BRANCH : PC_PLUS4)
                     : pc_src_q;
    assign state_o   = STATE_W'(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_FETCH;
            mem.mem_req     <= 1'b0;
            mem.mem_we      <= 1'b0;
            mem.mem_size    <= 1'b0;
            mem.mem_is_data <= 1'b0;
            pc_src_q        <= PC_PLUS4;
            wb_sel          <= WB_ALU;
            alu_src_imm     <= 1'b0;
            alu_op          <= '0;
            illegal         <= 1'b0;
        end else begin
            state           <= state_nx;
            mem.mem_req     <= (state_nx == ST_FETCH) || (state_nx == ST_MEM);
            mem.mem_we      <= (state_nx == ST_MEM) && is_s;
            mem.mem_size    <= (state_nx == ST_MEM) ? size : 1'b1;
            mem.mem_is_data <= (state_nx == ST_MEM);
            pc_src_q        <= (state_nx == ST_JUMP) ? (is_jal ? PC_BRANCH : PC_JALR) : PC_PLUS4;
            if (state_nx == ST_JUMP)
                wb_sel <= WB_PC4;
            else if (((state_nx == ST_WB) || (state_nx == ST_MEM)) && is_l)
                wb_sel <= WB_MEM;
            else
                wb_sel <= WB_ALU;
            // Address generation in EXEC/MEM keeps the immediate operand selected.
            alu_src_imm     <= ((state_nx == ST_EXEC) && !is_r) || (state_nx == ST_MEM);
            if (state_nx == ST_EXEC)
                alu_op <= ALU_OPW'(alu_code);
            else if (state_nx == ST_BRANCH)
                alu_op <= ALU_OPW'(ALU_SUB);
            else
                alu_op <= ALU_OPW'(ALU_ADD);
            illegal         <= illegal || (state_nx == ST_TRAP);
        end
    end

endmodule
